// File: rtl/en_gen_pkg.sv
// Shared types and default widths for the enable-pulse generator.
package en_gen_pkg;

   localparam int DEF_DIV_W   = 8;
   localparam int DEF_BURST_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } en_state_e;

endpackage

// File: rtl/en_prescaler.sv
// Free-running divide-by-(div_q+1) prescaler; tick marks the last cycle of each period.
module en_prescaler
   import en_gen_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [DIV_W-1:0] div_q,
   output logic             tick
);

   logic [DIV_W-1:0] pre_q;
   logic [DIV_W-1:0] pre_d;

   assign tick = run && (pre_q == div_q);

   always_comb begin
      pre_d = pre_q;
      if (clear) begin
         pre_d = '0;
      end else if (run) begin
         pre_d = (pre_q == div_q) ? '0 : pre_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/en_pulse_gen.sv
// Burst/continuous enable-strobe generator: IDLE/RUN/DONE FSM plus pulse counter,
// driving a downstream counter's en input at a programmable rate.
module en_pulse_gen
   import en_gen_pkg::*;
#(
   parameter int DIV_W   = DEF_DIV_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [DIV_W-1:0]   div,
   input  logic [BURST_W-1:0] burst_len,
   output logic               en,
   output logic               busy,
   output logic               done
);

   en_state_e          state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [BURST_W-1:0] pcnt_q, pcnt_d;
   logic               tick;
   logic               in_run;

   assign in_run = (state_q == RUN);

   en_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (!in_run),
      .run   (in_run),
      .div_q (div_q),
      .tick  (tick)
   );

   // Outputs are masked while rst is high so nothing leaks out during the reset cycle.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      burst_d = burst_q;
      pcnt_d  = pcnt_q;
      en      = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = RUN;
               div_d   = div;
               burst_d = burst_len;
               pcnt_d  = '0;
            end
         end
         RUN: begin
            busy = !rst;
            if (stop) begin
               state_d = IDLE;
            end else if (tick) begin
               en     = !rst;
               pcnt_d = pcnt_q + BURST_W'(1);
               if ((burst_q != '0) && (pcnt_q == burst_q - BURST_W'(1))) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = !stop && !rst;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         burst_q <= '0;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         burst_q <= burst_d;
         pcnt_q  <= pcnt_d;
      end
   end

endmodule

// File: tb/tb_en_pulse_gen.sv
// Scoreboard bench for en_pulse_gen: each scenario queues the expected per-cycle
// {en,busy,done} and pops one entry per cycle when sampling the DUT.
module tb_en_pulse_gen;

   localparam int DIV_W   = 8;
   localparam int BURST_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic [DIV_W-1:0]   div;
   logic [BURST_W-1:0] burst_len;
   logic               en;
   logic               busy;
   logic               done;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic en;
      logic busy;
      logic done;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   en_pulse_gen #(
      .DIV_W   (DIV_W),
      .BURST_W (BURST_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .div       (div),
      .burst_len (burst_len),
      .en        (en),
      .busy      (busy),
      .done      (done)
   );

   // Expected RUN cycles of a burst followed by the DONE cycle.
   function automatic void push_burst(input int d, input int n);
      for (int k = 1; k <= n * (d + 1); k++) begin
         exp_q.push_back('{en: ((k % (d + 1)) == 0), busy: 1'b1, done: 1'b0});
      end
      exp_q.push_back('{en: 1'b0, busy: 1'b0, done: 1'b1});
   endfunction

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 4; i++) exp_q.push_back('0);
      for (int i = 0; i < 4; i++) begin
         rst       = (i < 2);
         start     = (i < 2);
         stop      = 1'b0;
         div       = DIV_W'(5);
         burst_len = BURST_W'(2);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL reset cyc %0d: en/busy/done got %b want %b", i, {en, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_burst(input string nm, input int d, input int n, input bit poke);
      exp_t e;
      int   total;
      int   pulses = 0;
      int   busy_cnt = 0;
      total = n * (d + 1) + 3;
      exp_q.push_back('0);
      push_burst(d, n);
      exp_q.push_back('0);
      for (int i = 0; i < total; i++) begin
         start     = (i == 0) || (poke && (i >= 2) && (i <= 4));
         div       = (i == 0) ? DIV_W'(d) : DIV_W'(d + 3);
         burst_len = (i == 0) ? BURST_W'(n) : BURST_W'(n + 2);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL %s cyc %0d: en/busy/done got %b want %b", nm, i, {en, busy, done}, e);
         end
         if (en === 1'b1) pulses++;
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++;
      if (pulses != n) begin
         errors++;
         $display("[TB] FAIL %s pulse_count: got %0d want %0d", nm, pulses, n);
      end
      checks++;
      if (busy_cnt != n * (d + 1)) begin
         errors++;
         $display("[TB] FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, n * (d + 1));
      end
   endtask

   task automatic test_continuous(input string nm, input int d, input int run_cycles);
      exp_t e;
      int   pulses = 0;
      exp_q.push_back('0);
      for (int k = 1; k <= run_cycles; k++) begin
         exp_q.push_back('{en: ((k % (d + 1)) == 0), busy: 1'b1, done: 1'b0});
      end
      exp_q.push_back('{en: 1'b0, busy: 1'b1, done: 1'b0});
      exp_q.push_back('0);
      exp_q.push_back('0);
      for (int i = 0; i < run_cycles + 4; i++) begin
         start     = (i == 0);
         stop      = (i == run_cycles + 1);
         div       = DIV_W'(d);
         burst_len = '0;
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL %s cyc %0d: en/busy/done got %b want %b", nm, i, {en, busy, done}, e);
         end
         if (en === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      checks++;
      if (pulses != run_cycles / (d + 1)) begin
         errors++;
         $display("[TB] FAIL %s pulse_count: got %0d want %0d", nm, pulses, run_cycles / (d + 1));
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   pulses = 0;
      exp_q.push_back('0);
      for (int k = 1; k <= 4; k++) exp_q.push_back('{en: ((k % 2) == 0), busy: 1'b1, done: 1'b0});
      exp_q.push_back('0);
      exp_q.push_back('0);
      push_burst(1, 5);
      exp_q.push_back('0);
      for (int i = 0; i < 19; i++) begin
         rst       = (i == 5);
         start     = (i == 0) || (i == 6);
         div       = DIV_W'(1);
         burst_len = BURST_W'(5);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid cyc %0d: en/busy/done got %b want %b", i, {en, busy, done}, e);
         end
         if ((i >= 7) && (en === 1'b1)) pulses++;
         @(posedge clk); #1;
      end
      rst   = 1'b0;
      start = 1'b0;
      checks++;
      if (pulses != 5) begin
         errors++;
         $display("[TB] FAIL reset_mid restart_pulses: got %0d want 5", pulses);
      end
   endtask

   task automatic test_start_stop_idle();
      exp_t e;
      for (int i = 0; i < 11; i++) exp_q.push_back('0);
      for (int i = 0; i < 11; i++) begin
         start     = (i < 10);
         stop      = (i < 10);
         div       = '0;
         burst_len = BURST_W'(1);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL start_stop_idle cyc %0d: en/busy/done got %b want %b", i, {en, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_stop_in_done();
      exp_t e;
      exp_q.push_back('0);
      exp_q.push_back('{en: 1'b1, busy: 1'b1, done: 1'b0});
      exp_q.push_back('0);
      exp_q.push_back('0);
      push_burst(0, 2);
      exp_q.push_back('0);
      for (int i = 0; i < 8; i++) begin
         start     = (i == 0) || (i == 3);
         stop      = (i == 2);
         div       = '0;
         burst_len = (i == 0) ? BURST_W'(1) : BURST_W'(2);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({en, busy, done} !== e) begin
            errors++;
            $display("[TB] FAIL stop_in_done cyc %0d: en/busy/done got %b want %b", i, {en, busy, done}, e);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      div       = '0;
      burst_len = '0;
      test_reset();
      test_burst("div0_burst3", 0, 3, 1'b0);
      test_burst("div2_burst4", 2, 4, 1'b0);
      test_continuous("div1_cont", 1, 20);
      test_burst("start_in_run", 1, 3, 1'b1);
      test_reset_mid();
      test_start_stop_idle();
      test_stop_in_done();
      test_continuous("div0_wrap", 0, 300);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/en_pulse_gen.md
EN_PULSE_GEN -- requirements
Module: en_pulse_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of the prescaler divide value.
REQ-002 Parameter BURST_W, default 8, width of the burst pulse count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a pulse sequence; honoured only in IDLE.
REQ-006 stop  input  1  abort request; honoured in RUN and DONE.
REQ-007 div  input  DIV_W  divide value; en period = div+1 cycles; sampled on accepted start.
REQ-008 burst_len  input  BURST_W  number of en pulses; 0 = continuous; sampled on accepted start.
REQ-009 en  output  1  single-cycle enable strobe for the downstream simple_counter en input.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  single-cycle pulse on normal burst completion.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-013 IDLE->RUN when start=1 and stop=0; div_q<=div, burst_q<=burst_len, pre<=0, pcnt<=0.
REQ-014 start=1 with stop=1 in IDLE: start ignored, remain IDLE.
REQ-015 en SHALL be (state==RUN) && (pre==div_q) && !stop, combinational from registered state only.
REQ-016 In RUN, pre: 0 when pre==div_q, else pre+1; first en in the (div_q+1)th RUN cycle.
REQ-017 div_q=0: en high on every RUN cycle, starting the cycle after the start edge.
REQ-018 pcnt SHALL increment on each en; it is BURST_W bits and never wraps in burst mode.
REQ-019 burst_q!=0: en with pcnt==burst_q-1 SHALL move RUN->DONE on the next edge.
REQ-020 burst_q==0: RUN persists until stop; pcnt wraps modulo 2^BURST_W without effect.
REQ-021 DONE lasts exactly one cycle with done=1, then IDLE; stop in DONE forces done=0 and IDLE.
REQ-022 stop=1 in RUN: en=0 that cycle, next state IDLE, done never asserted.
REQ-023 start in RUN or DONE SHALL be ignored; div/burst_len changes after acceptance have no effect.
REQ-024 busy = (state==RUN); en and done SHALL never both be 1 in the same cycle.

Reset
REQ-025 rst=1 at any edge: state=IDLE, pre=0, pcnt=0, div_q=0, burst_q=0, regardless of state.
REQ-026 During and the cycle after reset: en=0, busy=0, done=0; rst overrides start and stop.
REQ-027 Reset mid-burst SHALL abort without a done pulse; a new start is accepted the first cycle after rst deasserts.

Structure
REQ-028 Package en_gen_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and default DIV_W/BURST_W constants.
REQ-029 Prescaler SHALL be sub-module en_prescaler (clk, rst, clear, run, div_q -> tick); FSM and pcnt remain in en_pulse_gen.
REQ-030 No latches; all outputs fully assigned in every state.

Verification
REQ-031 Reset, then start with div=0, burst_len=3 -> en high 3 consecutive cycles from the cycle after start, done 1 cycle later, busy high exactly 3 cycles.
REQ-032 div=2, burst_len=4 -> en at RUN cycles 3,6,9,12; done on cycle 13; downstream simple_counter (MAX=5) advances 0->4.
REQ-033 div=1, burst_len=0, stop asserted after 20 RUN cycles -> 10 en pulses, en=0 on the stop cycle, no done, IDLE next cycle.
REQ-034 Start during RUN with different div/burst_len -> ignored; original sequence completes unchanged.
REQ-035 rst pulsed mid-burst (after 2 of 5 pulses) -> en, busy, done low next cycle, no done; fresh start then yields full 5-pulse burst.
REQ-036 start and stop asserted together in IDLE -> stays IDLE, en=0, busy=0 for 10 cycles.
